// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM encoding and digit limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } sw_state_t;

  localparam logic [3:0] DIG_MAX_UNITS    = 4'd9;
  localparam logic [3:0] DIG_MAX_TENS_SEC = 4'd5;

  // Prescaler and count advance only while the watch is running (display frozen or not).
  function automatic logic is_counting(input sw_state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit that rolls over at MAX and raises carry on the rollover increment.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = DIG_MAX_UNITS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic at_max;

  assign at_max = (q == MAX);
  assign carry  = inc & at_max;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= at_max ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// SS.hh stopwatch: button edge detect, hundredths prescaler, run/lap/stop FSM,
// four chained BCD digits and a lap snapshot feeding the seven-segment decoders.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       clear,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  localparam int unsigned     PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  sw_state_t        state;
  logic             start_q;
  logic             lap_q;
  logic             start_e;
  logic             lap_e;
  logic [PRE_W-1:0] pre;
  logic             tick;
  logic             count_clr;

  logic [3:0] live0, live1, live2, live3;
  logic [3:0] snap0, snap1, snap2, snap3;
  logic       carry0, carry1, carry2, carry3;

  assign start_e = btn_start & ~start_q;
  assign lap_e   = btn_lap & ~lap_q;
  assign tick    = is_counting(state) && (pre == PRE_LAST);

  // A lap press while stopped discards the count; a simultaneous start press takes precedence.
  assign count_clr = clear | ((state == STOP) & lap_e & ~start_e);

  // Edge history resets high so a button held through reset does not fire.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q <= 1'b1;
      lap_q   <= 1'b1;
      pre     <= '0;
    end else begin
      start_q <= btn_start;
      lap_q   <= btn_lap;
      if (count_clr || state == IDLE) begin
        pre <= '0;
      end else if (is_counting(state)) begin
        pre <= tick ? '0 : pre + 1'b1;
      end
    end
  end

  bcd_digit #(.MAX(DIG_MAX_UNITS)) u_digit0 (
    .clock (clock),
    .reset (reset),
    .clr   (count_clr),
    .inc   (tick),
    .q     (live0),
    .carry (carry0)
  );

  bcd_digit #(.MAX(DIG_MAX_UNITS)) u_digit1 (
    .clock (clock),
    .reset (reset),
    .clr   (count_clr),
    .inc   (carry0),
    .q     (live1),
    .carry (carry1)
  );

  bcd_digit #(.MAX(DIG_MAX_UNITS)) u_digit2 (
    .clock (clock),
    .reset (reset),
    .clr   (count_clr),
    .inc   (carry1),
    .q     (live2),
    .carry (carry2)
  );

  bcd_digit #(.MAX(DIG_MAX_TENS_SEC)) u_digit3 (
    .clock (clock),
    .reset (reset),
    .clr   (count_clr),
    .inc   (carry2),
    .q     (live3),
    .carry (carry3)
  );

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wrap <= 1'b0;
    end else begin
      wrap <= carry3;
    end
  end

  // Snapshot captures the count as it stood before this edge's increment.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state      <= IDLE;
      running    <= 1'b0;
      lap_active <= 1'b0;
      snap0      <= '0;
      snap1      <= '0;
      snap2      <= '0;
      snap3      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_e) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (start_e) begin
            state   <= STOP;
            running <= 1'b0;
          end else if (lap_e) begin
            state      <= LAP;
            lap_active <= 1'b1;
            snap0      <= live0;
            snap1      <= live1;
            snap2      <= live2;
            snap3      <= live3;
          end
        end
        LAP: begin
          if (start_e) begin
            state      <= STOP;
            running    <= 1'b0;
            lap_active <= 1'b0;
          end else if (lap_e) begin
            state      <= RUN;
            lap_active <= 1'b0;
          end
        end
        STOP: begin
          if (start_e) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (lap_e) begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          running    <= 1'b0;
          lap_active <= 1'b0;
        end
      endcase
    end
  end

  assign digit0 = lap_active ? snap0 : live0;
  assign digit1 = lap_active ? snap1 : live1;
  assign digit2 = lap_active ? snap2 : live2;
  assign digit3 = lap_active ? snap3 : live3;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd with TICK_DIV=4: per-cycle reference scoreboard,
// a hand-derived vector table, and directed wrap / reset / clear sequences.
module tb_stopwatch_bcd;

  localparam int unsigned TD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       running, lap_active, wrap;
  logic [15:0] shown;

  stopwatch_bcd #(.TICK_DIV(TD)) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_start  (btn_start),
    .btn_lap    (btn_lap),
    .clear      (clear),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .running    (running),
    .lap_active (lap_active),
    .wrap       (wrap)
  );

  always #5 clock = ~clock;

  assign shown = {digit3, digit2, digit1, digit0};

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [15:0] bcd16(input int v);
    logic [15:0] r;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: count kept as integer hundredths, pushed after every edge.
  typedef struct packed {
    logic [15:0] d;
    logic        run;
    logic        lap;
    logic        wr;
  } obs_t;

  obs_t sb_q[$];
  obs_t m_e, got_o, exp_o;
  int   m_state = 0;
  int   m_cnt = 0, m_snap = 0, m_pre = 0, m_old = 0;
  bit   m_sq = 1'b1, m_lq = 1'b1, m_wrap = 1'b0;
  bit   m_se, m_le, m_tk;

  always @(posedge clock) begin
    m_se   = btn_start && !m_sq;
    m_le   = btn_lap && !m_lq;
    m_sq   = btn_start;
    m_lq   = btn_lap;
    m_wrap = 1'b0;
    if (reset) begin
      m_state = 0; m_cnt = 0; m_snap = 0; m_pre = 0; m_sq = 1'b1; m_lq = 1'b1;
    end else if (clear) begin
      m_state = 0; m_cnt = 0; m_snap = 0; m_pre = 0;
    end else begin
      m_tk  = (m_state == 1 || m_state == 2) && (m_pre == int'(TD) - 1);
      m_old = m_cnt;
      if (m_state == 1 || m_state == 2) m_pre = m_tk ? 0 : m_pre + 1;
      if (m_tk) begin
        if (m_cnt == 5999) begin
          m_cnt  = 0;
          m_wrap = 1'b1;
        end else begin
          m_cnt++;
        end
      end
      case (m_state)
        0: if (m_se) m_state = 1;
        1: if (m_se) m_state = 3;
           else if (m_le) begin m_state = 2; m_snap = m_old; end
        2: if (m_se) m_state = 3;
           else if (m_le) m_state = 1;
        default: if (m_se) m_state = 1;
           else if (m_le) begin m_state = 0; m_cnt = 0; m_pre = 0; end
      endcase
    end
    m_e.d   = bcd16(m_state == 2 ? m_snap : m_cnt);
    m_e.run = (m_state == 1 || m_state == 2);
    m_e.lap = (m_state == 2);
    m_e.wr  = m_wrap;
    sb_q.push_back(m_e);
  end

  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_o = sb_q.pop_front();
      got_o = {shown, running, lap_active, wrap};
      check("scoreboard", 32'(got_o), 32'(exp_o));
    end
  end

  typedef struct {
    bit    bs;
    bit    bl;
    bit    cl;
    int    cycles;
    int    val;
    bit    run;
    bit    lap;
    string name;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input bit bs, input bit bl, input bit cl, input int cycles,
                         input int val, input bit run, input bit lap, input string name);
    vec_t v;
    v.bs = bs; v.bl = bl; v.cl = cl; v.cycles = cycles;
    v.val = val; v.run = run; v.lap = lap; v.name = name;
    vq.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bit changed;

    add_vec(1, 0, 0, 1,   0,  1, 0, "start");
    add_vec(0, 0, 0, 40,  10, 1, 0, "run_40");
    add_vec(0, 1, 0, 1,   10, 1, 1, "lap_enter");
    add_vec(0, 0, 0, 20,  10, 1, 1, "lap_frozen");
    add_vec(0, 1, 0, 1,   15, 1, 0, "lap_exit_live");
    add_vec(0, 0, 0, 2,   16, 1, 0, "run_more");
    add_vec(1, 0, 0, 1,   16, 0, 0, "stop");
    add_vec(0, 0, 0, 100, 16, 0, 0, "stop_hold");
    add_vec(1, 0, 0, 1,   16, 1, 0, "resume");
    add_vec(0, 0, 0, 2,   16, 1, 0, "resume_pre");
    add_vec(0, 0, 0, 1,   17, 1, 0, "resume_tick");
    add_vec(1, 1, 0, 1,   17, 0, 0, "start_beats_lap");
    add_vec(0, 0, 0, 1,   17, 0, 0, "stopped");
    add_vec(0, 1, 0, 1,   0,  0, 0, "lap_to_idle");
    add_vec(0, 0, 0, 3,   0,  0, 0, "idle_hold");
    add_vec(0, 1, 0, 1,   0,  0, 0, "idle_lap_ignored");
    add_vec(1, 0, 0, 1,   0,  1, 0, "restart");
    add_vec(0, 0, 0, 5,   1,  1, 0, "restart_tick");
    add_vec(1, 0, 1, 1,   0,  0, 0, "clear_beats_start");
    add_vec(1, 0, 0, 3,   0,  0, 0, "held_no_edge");

    // Reset with btn_start held high throughout.
    reset = 1'b1;
    btn_start = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_digits", 32'(shown), 32'(0));
    check("rst_running", 32'(running), 32'(0));
    check("rst_lap", 32'(lap_active), 32'(0));
    check("rst_wrap", 32'(wrap), 32'(0));
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("held_through_reset", 32'(running), 32'(0));
    btn_start = 1'b0;
    repeat (2) @(negedge clock);

    foreach (vq[i]) begin
      btn_start = vq[i].bs;
      btn_lap   = vq[i].bl;
      clear     = vq[i].cl;
      repeat (vq[i].cycles) @(negedge clock);
      check({vq[i].name, "_digits"}, 32'(shown), 32'(bcd16(vq[i].val)));
      check({vq[i].name, "_flags"}, 32'({running, lap_active}), 32'({vq[i].run, vq[i].lap}));
    end
    btn_lap = 1'b0;
    clear   = 1'b0;

    // Run all the way to 59.99 and across the wrap.
    btn_start = 1'b0;
    @(negedge clock);
    btn_start = 1'b1;
    @(negedge clock);
    btn_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30000 && !found; i++) begin
      @(negedge clock);
      if (shown == bcd16(5999)) found = 1'b1;
    end
    check("reach_5999", 32'(found), 32'(1));
    changed = 1'b0;
    for (int i = 0; i < 8 && !changed; i++) begin
      @(negedge clock);
      if (shown != bcd16(5999)) changed = 1'b1;
    end
    check("wrap_changed", 32'(changed), 32'(1));
    check("wrap_digits", 32'(shown), 32'(0));
    check("wrap_pulse", 32'(wrap), 32'(1));
    @(negedge clock);
    check("wrap_one_cycle", 32'(wrap), 32'(0));
    check("run_after_wrap", 32'(running), 32'(1));
    repeat (3) @(negedge clock);
    check("count_after_wrap", 32'(shown), 32'(bcd16(1)));

    // Clear in the middle of a run.
    repeat (6) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clear_digits", 32'(shown), 32'(0));
    check("clear_running", 32'(running), 32'(0));
    check("clear_lap", 32'(lap_active), 32'(0));
    repeat (5) @(negedge clock);
    check("idle_after_clear", 32'({shown, running}), 32'(0));

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Four-digit BCD stopwatch counting SS.hh (00.00–59.99) in hundredths of a second, with start/stop, lap-freeze and clear. Sits directly upstream of the four seven-segment decoders on the FPGA board. Each digit output is a 4-bit BCD value, always in the range 0–9, wired straight into one decoder's `in`. Button inputs arrive already debounced; rising edges are detected internally.

## Interface
- `TICK_DIV`, default 500000: clock cycles per hundredth of a second (50 MHz → 100 Hz). Legal values ≥ 2.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; overrides every other input.
- `btn_start`  in  1  debounced level; a rising edge toggles run/stop.
- `btn_lap`  in  1  debounced level; a rising edge freezes/unfreezes the display, or clears the count when stopped.
- `clear`  in  1  synchronous clear to IDLE, sampled every cycle; priority below `reset`.
- `digit0`  out  4  hundredths units (0–9).
- `digit1`  out  4  tenths (0–9).
- `digit2`  out  4  seconds units (0–9).
- `digit3`  out  4  seconds tens (0–5).
- `running`  out  1  high in RUN and LAP.
- `lap_active`  out  1  high in LAP (display frozen).
- `wrap`  out  1  one-cycle pulse when the count rolls 59.99 → 00.00.

## Operation
- Edge detect: `start_e = btn_start & ~start_q`; `lap_e = btn_lap & ~lap_q`.
  - `start_q` and `lap_q` reset to 1, so a button held through reset produces no edge.
- Prescaler `pre` has width `$clog2(TICK_DIV)`.
  - It increments only in RUN and LAP.
  - `tick` is asserted when `pre == TICK_DIV-1`; `pre` then returns to 0.
  - `pre` holds its value in STOP, so resume is seamless, and is zeroed in IDLE.
- Count: four cascaded BCD digits with limits 9, 9, 9, 5.
  - On `tick`, `digit0` increments; each digit carries into the next when it is at its limit.
  - All four digits at their limits plus `tick` → all digits become 0 and `wrap` pulses.
- Display path:
  - Outside LAP, the digit outputs show the live count.
  - On entry to LAP, the live count is copied into a snapshot register; outputs show the snapshot while counting continues underneath.
- State machine (states IDLE, RUN, LAP, STOP):
  - IDLE: count 0. `start_e` → RUN; `lap_e` ignored.
  - RUN: `start_e` → STOP; `lap_e` → LAP (snapshot taken).
  - LAP: `lap_e` → RUN (display live again); `start_e` → STOP (display live).
  - STOP: `start_e` → RUN; `lap_e` → IDLE (count and `pre` zeroed).
- Simultaneous events:
  - `start_e` and `lap_e` in the same cycle: `start_e` wins, `lap_e` is discarded.
  - `tick` coinciding with a RUN→STOP transition: the increment still applies.
  - `clear` together with any edge: `clear` wins.
- `clear` or `reset` mid-count: count, `pre`, snapshot and `wrap` all go to 0 and the state goes to IDLE.

## Timing
- Reset values: digits 0, `running` 0, `lap_active` 0, `wrap` 0, state IDLE, `pre` 0.
- Button rising on cycle N (sampled at edge N) → state and outputs change at edge N+1.
- `tick` at edge N → incremented digits visible after edge N+1. `wrap` is high for exactly that one cycle.
- Increment period in RUN/LAP is exactly `TICK_DIV` cycles, with no slip across LAP enter/exit.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `stopwatch_pkg` holds:
  - the state encoding (IDLE, RUN, LAP, STOP as 2-bit constants);
  - digit limit constants `DIG_MAX_UNITS` = 9 and `DIG_MAX_TENS_SEC` = 5.
- Sub-module `bcd_digit`:
  - parameter `MAX`;
  - inputs `clock`, `reset`, `clr`, `inc`;
  - outputs `q[3:0]`, `carry`, where `carry = inc & (q == MAX)`.
  - Instantiated four times and chained through `inc`/`carry`.
- Top level holds the edge detectors, prescaler, FSM and snapshot register.

## Test plan
Simulate with `TICK_DIV`=4 throughout.
- Reset, then `btn_start` pulse → `running`=1 one cycle later; after 40 cycles the digits read 00.10 (`digit1`=1, others 0).
- Run to 59.99, then one more tick → digits 00.00, `wrap` high for exactly one cycle, counting continues.
- At 00.05, `btn_lap` pulse → `lap_active`=1 and the display holds 00.05. After 20 more cycles, a second `btn_lap` pulse → display shows live 00.10.
- RUN → `btn_start` (STOP) → 100-cycle wait → digits unchanged → `btn_start` → next increment lands exactly `TICK_DIV` cycles after the last pre-stop increment minus the cycles already elapsed in `pre`.
- `btn_start` and `btn_lap` rising in the same cycle from RUN → STOP, `lap_active`=0. Then `btn_lap` in STOP → IDLE with digits 00.00.
- `btn_start` held high across reset deassert → no transition. `clear` asserted mid-RUN → next cycle IDLE, digits 0, `running`=0.
